// File: rtl/riscv_configs_pkg.sv
// ---------------------------------------------------------------------------
// riscv_configs
//   Shared definitions for the RV32 decode stage: default datapath width,
//   layout of the packed ID/EX control bundle, opcode constants, result
//   source encodings and the control-unit decode helpers.
//
//   Control bundle (MSB first, CTRL_W = 17):
//     reg_write | result_src[1:0] | mem_write | jump[1:0] | branch |
//     alu_control[3:0] | byte_sel[3:0] | alu_b_src | rd_src
// ---------------------------------------------------------------------------
package riscv_configs;

  localparam int XLEN_DEFAULT = 32;
  localparam int CTRL_W       = 17;

  // Bit offsets of each field inside the packed control bundle
  localparam int CTRL_REG_WRITE   = 16;
  localparam int CTRL_RESULT_SRC  = 14;
  localparam int CTRL_MEM_WRITE   = 13;
  localparam int CTRL_JUMP        = 11;
  localparam int CTRL_BRANCH      = 10;
  localparam int CTRL_ALU_CONTROL = 6;
  localparam int CTRL_BYTE_SEL    = 2;
  localparam int CTRL_ALU_B_SRC   = 1;
  localparam int CTRL_RD_SRC      = 0;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Writeback value selection; LOAD is what the hazard unit looks for
  localparam logic [1:0] RESULT_SRC_ALU    = 2'b00;
  localparam logic [1:0] RESULT_SRC_LOAD   = 2'b01;
  localparam logic [1:0] RESULT_SRC_PC4    = 2'b10;
  localparam logic [1:0] RESULT_SRC_PC_IMM = 2'b11;

  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_JAL  = 2'b01;
  localparam logic [1:0] JUMP_JALR = 2'b10;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  // Field order here is the bit layout of o_ex_ctrl
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic [1:0] jump;
    logic       branch;
    alu_op_e    alu_control;
    logic [3:0] byte_sel;
    logic       alu_b_src;
    logic       rd_src;     // 1: rd takes the upper immediate directly (LUI)
  } ctrl_t;

  // alt selects SUB over ADD and SRA over SRL
  function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Byte lanes touched by a load/store; funct3[2] only marks unsigned loads
  function automatic logic [3:0] byte_sel_decode(input logic [1:0] size);
    logic [3:0] sel;
    case (size)
      2'b00:   sel = 4'b0001;
      2'b01:   sel = 4'b0011;
      2'b10:   sel = 4'b1111;
      default: sel = 4'b0000;
    endcase
    return sel;
  endfunction

  // Main control unit
  function automatic ctrl_t decode_ctrl(input logic [6:0] opcode,
                                        input logic [2:0] funct3,
                                        input logic       funct7_b5);
    ctrl_t c;
    c = '0;
    case (opcode)
      OPC_LUI: begin
        c.reg_write = 1'b1;
        c.rd_src    = 1'b1;
      end
      OPC_AUIPC: begin
        c.reg_write  = 1'b1;
        c.result_src = RESULT_SRC_PC_IMM;
      end
      OPC_JAL: begin
        c.reg_write  = 1'b1;
        c.result_src = RESULT_SRC_PC4;
        c.jump       = JUMP_JAL;
      end
      OPC_JALR: begin
        c.reg_write  = 1'b1;
        c.result_src = RESULT_SRC_PC4;
        c.jump       = JUMP_JALR;
        c.alu_b_src  = 1'b1;
      end
      OPC_BRANCH: begin
        c.branch      = 1'b1;
        c.alu_control = ALU_SUB;
      end
      OPC_LOAD: begin
        c.reg_write  = 1'b1;
        c.result_src = RESULT_SRC_LOAD;
        c.alu_b_src  = 1'b1;
        c.byte_sel   = byte_sel_decode(funct3[1:0]);
      end
      OPC_STORE: begin
        c.mem_write = 1'b1;
        c.alu_b_src = 1'b1;
        c.byte_sel  = byte_sel_decode(funct3[1:0]);
      end
      OPC_OP_IMM: begin
        // bit 30 is immediate data except for SRAI
        c.reg_write   = 1'b1;
        c.alu_b_src   = 1'b1;
        c.alu_control = alu_decode(funct3, funct7_b5 && (funct3 == 3'b101));
      end
      OPC_OP: begin
        c.reg_write   = 1'b1;
        c.alu_control = alu_decode(funct3, funct7_b5);
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/riscv_id_hazard.sv
// ---------------------------------------------------------------------------
// riscv_id_hazard
//   Purely combinational operand-usage decode and load-use hazard detection.
//
//   Ports:
//     opcode, rs1_addr, rs2_addr      : fields of the instruction in ID
//     id_valid                        : ID holds a real instruction
//     ex_valid, ex_result_src,
//     ex_rd_addr                      : state of the instruction in ID/EX
//     ex_flush                        : taken branch/jump kill
//     use_rs1, use_rs2                : operand actually read by the opcode
//     stall                           : hold IF/ID and insert a bubble
// ---------------------------------------------------------------------------
module riscv_id_hazard
  import riscv_configs::*;
(
  input  logic [6:0] opcode,
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic       id_valid,
  input  logic       ex_valid,
  input  logic [1:0] ex_result_src,
  input  logic [4:0] ex_rd_addr,
  input  logic       ex_flush,
  output logic       use_rs1,
  output logic       use_rs2,
  output logic       stall
);

  logic load_in_ex;
  logic rs1_match;
  logic rs2_match;

  assign use_rs1 = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
  assign use_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

  // x0 is never a real producer, so a load into x0 cannot create a hazard
  assign load_in_ex = ex_valid && (ex_result_src == RESULT_SRC_LOAD) && (ex_rd_addr != 5'd0);
  assign rs1_match  = use_rs1 && (rs1_addr == ex_rd_addr);
  assign rs2_match  = use_rs2 && (rs2_addr == ex_rd_addr);

  // A flush kills the ID instruction anyway, so there is nothing to hold
  assign stall = id_valid && load_in_ex && (rs1_match || rs2_match) && !ex_flush;

endmodule

// File: rtl/riscv_id_pipe.sv
// ---------------------------------------------------------------------------
// riscv_id_pipe
//   RV32I/RV32E instruction decode stage with register file, WB-to-ID bypass,
//   load-use stall and the ID/EX pipeline register (1-cycle latency).
//
//   Parameters: XLEN (datapath width), NREG (32 = RV32I, 16 = RV32E),
//               WB_BYPASS (1 = same-cycle WB-to-ID operand bypass).
//   Ports:
//     i_clk, i_rstn                   : clock, synchronous active-low reset
//     i_id_valid, i_id_instr, i_id_pc : instruction in ID
//     i_id_wb_reg_write, i_id_rd_addr,
//     i_id_rd_data                    : writeback port into the register file
//     i_ex_flush                      : kill the instruction in ID
//     o_id_stall                      : hold IF/ID (combinational)
//     o_ex_*                          : registered ID/EX slot
//     o_id_stall_cnt                  : saturating count of stall cycles
// ---------------------------------------------------------------------------
module riscv_id_pipe
  import riscv_configs::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter int NREG      = 32,
  parameter int WB_BYPASS = 1
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_id_valid,
  input  logic [XLEN-1:0]   i_id_instr,
  input  logic [XLEN-1:0]   i_id_pc,
  input  logic              i_id_wb_reg_write,
  input  logic [4:0]        i_id_rd_addr,
  input  logic [XLEN-1:0]   i_id_rd_data,
  input  logic              i_ex_flush,
  output logic              o_id_stall,
  output logic              o_ex_valid,
  output logic [XLEN-1:0]   o_ex_pc,
  output logic [XLEN-1:0]   o_ex_rs1_data,
  output logic [XLEN-1:0]   o_ex_rs2_data,
  output logic [4:0]        o_ex_rs1_addr,
  output logic [4:0]        o_ex_rs2_addr,
  output logic [4:0]        o_ex_rd_addr,
  output logic [XLEN-1:0]   o_ex_imm,
  output logic [2:0]        o_ex_funct3,
  output logic [CTRL_W-1:0] o_ex_ctrl,
  output logic              o_ex_illegal,
  output logic [31:0]       o_id_stall_cnt
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] rf [NREG];

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [4:0]      rd_addr;
  logic [2:0]      funct3;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_ext;
  ctrl_t           dec_ctrl;
  ctrl_t           ctrl_next;
  logic            use_rs1;
  logic            use_rs2;
  logic            stall;
  logic            issue;
  logic            illegal;
  logic            rs1_ok;
  logic            rs2_ok;
  logic            rd_ok;
  logic            rs1_bypass;
  logic            rs2_bypass;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  logic            ex_valid_q;
  logic [XLEN-1:0] ex_pc_q;
  logic [XLEN-1:0] ex_rs1_data_q;
  logic [XLEN-1:0] ex_rs2_data_q;
  logic [4:0]      ex_rs1_addr_q;
  logic [4:0]      ex_rs2_addr_q;
  logic [4:0]      ex_rd_addr_q;
  logic [XLEN-1:0] ex_imm_q;
  logic [2:0]      ex_funct3_q;
  ctrl_t           ex_ctrl_q;
  logic            ex_illegal_q;
  logic [31:0]     stall_cnt_q;

  assign instr    = i_id_instr[31:0];
  assign opcode   = instr[6:0];
  assign rd_addr  = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign dec_ctrl = decode_ctrl(opcode, funct3, instr[30]);

  // RV32E only has x0..x15, so any address with bit 4 set is out of range
  assign rs1_ok = (NREG >= 32) || !rs1_addr[4];
  assign rs2_ok = (NREG >= 32) || !rs2_addr[4];
  assign rd_ok  = (NREG >= 32) || !i_id_rd_addr[4];

  riscv_id_hazard u_hazard (
    .opcode        (opcode),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .id_valid      (i_id_valid),
    .ex_valid      (ex_valid_q),
    .ex_result_src (ex_ctrl_q.result_src),
    .ex_rd_addr    (ex_rd_addr_q),
    .ex_flush      (i_ex_flush),
    .use_rs1       (use_rs1),
    .use_rs2       (use_rs2),
    .stall         (stall)
  );

  // Register file write port; deliberately no reset, x0 is never stored
  always_ff @(posedge i_clk) begin
    if (i_id_wb_reg_write && (i_id_rd_addr != 5'd0) && rd_ok) begin
      rf[i_id_rd_addr[AW-1:0]] <= i_id_rd_data;
    end
  end

  assign rs1_bypass = (WB_BYPASS != 0) && i_id_wb_reg_write && (i_id_rd_addr == rs1_addr);
  assign rs2_bypass = (WB_BYPASS != 0) && i_id_wb_reg_write && (i_id_rd_addr == rs2_addr);

  // Operand read: x0 and out-of-range addresses read as zero, then the
  // writeback bypass beats the (not yet written) register file entry
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if ((rs1_addr != 5'd0) && rs1_ok) begin
      rs1_val = rs1_bypass ? i_id_rd_data : rf[rs1_addr[AW-1:0]];
    end
    if ((rs2_addr != 5'd0) && rs2_ok) begin
      rs2_val = rs2_bypass ? i_id_rd_data : rf[rs2_addr[AW-1:0]];
    end
  end

  // Immediate decoder, built at 32 bits and sign-extended to XLEN
  always_comb begin
    imm32 = '0;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm32 = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC: imm32 = {instr[31:12], 12'b0};
      OPC_JAL:    imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:    imm32 = '0;
    endcase
  end

  assign imm_ext = XLEN'($signed(imm32));

  assign illegal = (NREG < 32) &&
                   ((use_rs1 && rs1_addr[4]) || (use_rs2 && rs2_addr[4]) ||
                    (dec_ctrl.reg_write && rd_addr[4]));

  assign issue = i_id_valid && !i_ex_flush && !stall;

  // A bubble keeps the datapath fields and only drops side effects
  always_comb begin
    ctrl_next = dec_ctrl;
    if (illegal) begin
      ctrl_next.reg_write = 1'b0;
    end
    if (!issue) begin
      ctrl_next.reg_write = 1'b0;
      ctrl_next.mem_write = 1'b0;
      ctrl_next.branch    = 1'b0;
      ctrl_next.jump      = JUMP_NONE;
    end
  end

  // ID/EX register and stall counter
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_rs1_addr_q <= '0;
      ex_rs2_addr_q <= '0;
      ex_rd_addr_q  <= '0;
      ex_imm_q      <= '0;
      ex_funct3_q   <= '0;
      ex_ctrl_q     <= '0;
      ex_illegal_q  <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      ex_valid_q    <= issue;
      ex_pc_q       <= i_id_pc;
      ex_rs1_data_q <= rs1_val;
      ex_rs2_data_q <= rs2_val;
      ex_rs1_addr_q <= rs1_addr;
      ex_rs2_addr_q <= rs2_addr;
      ex_rd_addr_q  <= rd_addr;
      ex_imm_q      <= imm_ext;
      ex_funct3_q   <= funct3;
      ex_ctrl_q     <= ctrl_next;
      ex_illegal_q  <= issue && illegal;
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign o_id_stall     = stall;
  assign o_ex_valid     = ex_valid_q;
  assign o_ex_pc        = ex_pc_q;
  assign o_ex_rs1_data  = ex_rs1_data_q;
  assign o_ex_rs2_data  = ex_rs2_data_q;
  assign o_ex_rs1_addr  = ex_rs1_addr_q;
  assign o_ex_rs2_addr  = ex_rs2_addr_q;
  assign o_ex_rd_addr   = ex_rd_addr_q;
  assign o_ex_imm       = ex_imm_q;
  assign o_ex_funct3    = ex_funct3_q;
  assign o_ex_ctrl      = ex_ctrl_q;
  assign o_ex_illegal   = ex_illegal_q;
  assign o_id_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_riscv_id_pipe.sv
// ---------------------------------------------------------------------------
// tb_riscv_id_pipe
//   Directed bench for riscv_id_pipe. Three instances share one stimulus:
//   dut (defaults), dut_nb (WB_BYPASS=0) and dut_e (NREG=16, RV32E).
// ---------------------------------------------------------------------------
module tb_riscv_id_pipe;

  localparam logic [31:0] I_LW5   = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] I_ADD6  = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] I_SW5   = 32'h0050A423; // sw   x5,8(x1)
  localparam logic [31:0] I_ADD8  = 32'h00038433; // add  x8,x7,x0
  localparam logic [31:0] I_ADD9  = 32'h000004B3; // add  x9,x0,x0
  localparam logic [31:0] I_ADDIM = 32'hFFF08193; // addi x3,x1,-1
  localparam logic [31:0] I_ADD17 = 32'h002088B3; // add  x17,x1,x2

  logic        clk = 1'b0;
  logic        rstn;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;

  logic        stall, ex_valid, ex_illegal;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, stall_cnt;
  logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [2:0]  ex_funct3;
  logic [16:0] ex_ctrl;

  logic        nb_stall, nb_valid, nb_illegal;
  logic [31:0] nb_pc, nb_rs1_data, nb_rs2_data, nb_imm, nb_cnt;
  logic [4:0]  nb_rs1_addr, nb_rs2_addr, nb_rd_addr;
  logic [2:0]  nb_funct3;
  logic [16:0] nb_ctrl;

  logic        e_stall, e_valid, e_illegal;
  logic [31:0] e_pc, e_rs1_data, e_rs2_data, e_imm, e_cnt;
  logic [4:0]  e_rs1_addr, e_rs2_addr, e_rd_addr;
  logic [2:0]  e_funct3;
  logic [16:0] e_ctrl;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] follow_instr [3];
  logic [31:0] follow_imm   [3];

  always #5 clk = ~clk;

  riscv_id_pipe dut (
    .i_clk(clk), .i_rstn(rstn), .i_id_valid(id_valid), .i_id_instr(id_instr),
    .i_id_pc(id_pc), .i_id_wb_reg_write(wb_we), .i_id_rd_addr(wb_rd),
    .i_id_rd_data(wb_data), .i_ex_flush(flush), .o_id_stall(stall),
    .o_ex_valid(ex_valid), .o_ex_pc(ex_pc), .o_ex_rs1_data(ex_rs1_data),
    .o_ex_rs2_data(ex_rs2_data), .o_ex_rs1_addr(ex_rs1_addr),
    .o_ex_rs2_addr(ex_rs2_addr), .o_ex_rd_addr(ex_rd_addr), .o_ex_imm(ex_imm),
    .o_ex_funct3(ex_funct3), .o_ex_ctrl(ex_ctrl), .o_ex_illegal(ex_illegal),
    .o_id_stall_cnt(stall_cnt)
  );

  riscv_id_pipe #(.WB_BYPASS(0)) dut_nb (
    .i_clk(clk), .i_rstn(rstn), .i_id_valid(id_valid), .i_id_instr(id_instr),
    .i_id_pc(id_pc), .i_id_wb_reg_write(wb_we), .i_id_rd_addr(wb_rd),
    .i_id_rd_data(wb_data), .i_ex_flush(flush), .o_id_stall(nb_stall),
    .o_ex_valid(nb_valid), .o_ex_pc(nb_pc), .o_ex_rs1_data(nb_rs1_data),
    .o_ex_rs2_data(nb_rs2_data), .o_ex_rs1_addr(nb_rs1_addr),
    .o_ex_rs2_addr(nb_rs2_addr), .o_ex_rd_addr(nb_rd_addr), .o_ex_imm(nb_imm),
    .o_ex_funct3(nb_funct3), .o_ex_ctrl(nb_ctrl), .o_ex_illegal(nb_illegal),
    .o_id_stall_cnt(nb_cnt)
  );

  riscv_id_pipe #(.NREG(16)) dut_e (
    .i_clk(clk), .i_rstn(rstn), .i_id_valid(id_valid), .i_id_instr(id_instr),
    .i_id_pc(id_pc), .i_id_wb_reg_write(wb_we), .i_id_rd_addr(wb_rd),
    .i_id_rd_data(wb_data), .i_ex_flush(flush), .o_id_stall(e_stall),
    .o_ex_valid(e_valid), .o_ex_pc(e_pc), .o_ex_rs1_data(e_rs1_data),
    .o_ex_rs2_data(e_rs2_data), .o_ex_rs1_addr(e_rs1_addr),
    .o_ex_rs2_addr(e_rs2_addr), .o_ex_rd_addr(e_rd_addr), .o_ex_imm(e_imm),
    .o_ex_funct3(e_funct3), .o_ex_ctrl(e_ctrl), .o_ex_illegal(e_illegal),
    .o_id_stall_cnt(e_cnt)
  );

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of ID inputs just after the falling edge
  task automatic applyStimulus(input logic v, input logic [31:0] ins,
                               input logic [31:0] pc, input logic we,
                               input logic [4:0] rd, input logic [31:0] data,
                               input logic fl);
    @(negedge clk);
    id_valid = v;
    id_instr = ins;
    id_pc    = pc;
    wb_we    = we;
    wb_rd    = rd;
    wb_data  = data;
    flush    = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    follow_instr[0] = 32'h123452B7; follow_imm[0] = 32'h1234_5000; // lui  x5,0x12345
    follow_instr[1] = 32'h00028337; follow_imm[1] = 32'h0002_8000; // lui  x6,0x28 (rs1 field = 5)
    follow_instr[2] = 32'h00508193; follow_imm[2] = 32'h0000_0005; // addi x3,x1,5 (rs2 field = 5)

    // Reset with a live instruction present
    rstn = 1'b0;
    id_valid = 1'b1; id_instr = I_ADD6; id_pc = 32'h40;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
    tick();
    tick();
    checkOutput("rst_valid", 32'(ex_valid), 32'd0);
    checkOutput("rst_pc", ex_pc, 32'd0);
    checkOutput("rst_ctrl", 32'(ex_ctrl), 32'd0);
    checkOutput("rst_imm", ex_imm, 32'd0);
    checkOutput("rst_rd", 32'(ex_rd_addr), 32'd0);
    checkOutput("rst_cnt", stall_cnt, 32'd0);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Preload registers through the WB port with no instruction in ID
    applyStimulus(0, I_ADD6, 32'h0, 1, 5'd1, 32'h0000_0100, 0);
    checkOutput("invalid_no_stall", 32'(stall), 32'd0);
    tick();
    applyStimulus(0, I_ADD6, 32'h0, 1, 5'd2, 32'h0000_0022, 0); tick();
    applyStimulus(0, I_ADD6, 32'h0, 1, 5'd5, 32'h0000_0055, 0); tick();
    applyStimulus(0, I_ADD6, 32'h0, 1, 5'd7, 32'h1111_1111, 0); tick();
    checkOutput("invalid_bubble", 32'(ex_valid), 32'd0);

    // Load-use: LW x5 then ADD x6,x5,x2
    applyStimulus(1, I_LW5, 32'h100, 0, 5'd0, 32'h0, 0);
    checkOutput("lw_no_stall", 32'(stall), 32'd0);
    tick();
    checkOutput("lw_valid", 32'(ex_valid), 32'd1);
    checkOutput("lw_ctrl", 32'(ex_ctrl), 32'h0001_403E);
    checkOutput("lw_rd", 32'(ex_rd_addr), 32'd5);
    checkOutput("lw_rs1_data", ex_rs1_data, 32'h0000_0100);
    checkOutput("lw_funct3", 32'(ex_funct3), 32'd2);
    applyStimulus(1, I_ADD6, 32'h104, 0, 5'd0, 32'h0, 0);
    checkOutput("lu_stall", 32'(stall), 32'd1);
    tick();
    checkOutput("lu_bubble_valid", 32'(ex_valid), 32'd0);
    checkOutput("lu_bubble_pc", ex_pc, 32'h0000_0104);
    checkOutput("lu_bubble_ctrl", 32'(ex_ctrl), 32'd0);
    checkOutput("lu_cnt", stall_cnt, 32'd1);
    applyStimulus(1, I_ADD6, 32'h104, 0, 5'd0, 32'h0, 0);
    checkOutput("lu_stall_once", 32'(stall), 32'd0);
    tick();
    checkOutput("add_valid", 32'(ex_valid), 32'd1);
    checkOutput("add_ctrl", 32'(ex_ctrl), 32'h0001_0000);
    checkOutput("add_rs1_data", ex_rs1_data, 32'h0000_0055);
    checkOutput("add_rs2_data", ex_rs2_data, 32'h0000_0022);
    checkOutput("add_rd", 32'(ex_rd_addr), 32'd6);
    checkOutput("add_cnt", stall_cnt, 32'd1);
    checkOutput("e_add_legal", 32'(e_illegal), 32'd0);

    // No false stall when the follower does not really read x5
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, I_LW5, 32'h200, 0, 5'd0, 32'h0, 0);
      tick();
      applyStimulus(1, follow_instr[k], 32'h204, 0, 5'd0, 32'h0, 0);
      checkOutput($sformatf("nostall_%0d", k), 32'(stall), 32'd0);
      tick();
      checkOutput($sformatf("nostall_valid_%0d", k), 32'(ex_valid), 32'd1);
      checkOutput($sformatf("nostall_imm_%0d", k), ex_imm, follow_imm[k]);
    end
    checkOutput("nostall_cnt", stall_cnt, 32'd1);

    // Flush overrides the hazard
    applyStimulus(1, I_LW5, 32'h300, 0, 5'd0, 32'h0, 0);
    tick();
    applyStimulus(1, I_ADD6, 32'h304, 0, 5'd0, 32'h0, 1);
    checkOutput("flush_no_stall", 32'(stall), 32'd0);
    tick();
    checkOutput("flush_bubble", 32'(ex_valid), 32'd0);
    checkOutput("flush_cnt", stall_cnt, 32'd1);

    // Store data (rs2) dependency also stalls
    applyStimulus(1, I_LW5, 32'h400, 0, 5'd0, 32'h0, 0);
    tick();
    applyStimulus(1, I_SW5, 32'h404, 0, 5'd0, 32'h0, 0);
    checkOutput("sw_stall", 32'(stall), 32'd1);
    tick();
    checkOutput("sw_bubble_valid", 32'(ex_valid), 32'd0);
    checkOutput("sw_bubble_imm", ex_imm, 32'd8);
    checkOutput("sw_cnt", stall_cnt, 32'd2);
    applyStimulus(1, I_SW5, 32'h404, 0, 5'd0, 32'h0, 0);
    tick();
    checkOutput("sw_valid", 32'(ex_valid), 32'd1);
    checkOutput("sw_ctrl", 32'(ex_ctrl), 32'h0000_203E);
    checkOutput("sw_rs2_data", ex_rs2_data, 32'h0000_0055);

    // Same-cycle WB bypass on x7
    applyStimulus(1, I_ADD8, 32'h500, 1, 5'd7, 32'hDEAD_BEEF, 0);
    tick();
    checkOutput("bypass_rs1", ex_rs1_data, 32'hDEAD_BEEF);
    checkOutput("bypass_rs2_x0", ex_rs2_data, 32'd0);
    checkOutput("nobypass_rs1", nb_rs1_data, 32'h1111_1111);
    applyStimulus(1, I_ADD8, 32'h504, 0, 5'd0, 32'h0, 0);
    tick();
    checkOutput("nobypass_written", nb_rs1_data, 32'hDEAD_BEEF);

    // x0 stays zero under a write and a same-cycle bypass attempt
    applyStimulus(1, I_ADD9, 32'h600, 1, 5'd0, 32'hFFFF_FFFF, 0);
    tick();
    checkOutput("x0_bypass", ex_rs1_data, 32'd0);
    applyStimulus(1, I_ADD9, 32'h604, 0, 5'd0, 32'h0, 0);
    tick();
    checkOutput("x0_read", ex_rs1_data, 32'd0);
    checkOutput("x0_read_nb", nb_rs2_data, 32'd0);

    // Negative I-type immediate
    applyStimulus(1, I_ADDIM, 32'h700, 0, 5'd0, 32'h0, 0);
    tick();
    checkOutput("addi_imm", ex_imm, 32'hFFFF_FFFF);
    checkOutput("addi_ctrl", 32'(ex_ctrl), 32'h0001_0002);

    // RV32E: rd x17 is illegal and loses its register write
    applyStimulus(1, I_ADD17, 32'h800, 0, 5'd0, 32'h0, 0);
    tick();
    checkOutput("e_illegal", 32'(e_illegal), 32'd1);
    checkOutput("e_valid", 32'(e_valid), 32'd1);
    checkOutput("e_ctrl", 32'(e_ctrl), 32'd0);
    checkOutput("i_legal", 32'(ex_illegal), 32'd0);
    checkOutput("i_ctrl", 32'(ex_ctrl), 32'h0001_0000);

    // Reset asserted during a stall cycle
    applyStimulus(1, I_LW5, 32'h900, 0, 5'd0, 32'h0, 0);
    tick();
    applyStimulus(1, I_ADD6, 32'h904, 0, 5'd0, 32'h0, 0);
    checkOutput("rststall_stall", 32'(stall), 32'd1);
    rstn = 1'b0;
    tick();
    checkOutput("rststall_valid", 32'(ex_valid), 32'd0);
    checkOutput("rststall_pc", ex_pc, 32'd0);
    checkOutput("rststall_ctrl", 32'(ex_ctrl), 32'd0);
    checkOutput("rststall_rs1", ex_rs1_data, 32'd0);
    checkOutput("rststall_cnt", stall_cnt, 32'd0);
    checkOutput("rststall_after", 32'(stall), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Counter saturation from a preloaded all-ones value
    applyStimulus(1, I_LW5, 32'hA00, 0, 5'd0, 32'h0, 0);
    tick();
    applyStimulus(1, I_ADD6, 32'hA04, 0, 5'd0, 32'h0, 0);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    checkOutput("sat_stall", 32'(stall), 32'd1);
    tick();
    checkOutput("sat_cnt", stall_cnt, 32'hFFFF_FFFF);
    checkOutput("sat_nb_cnt", nb_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/riscv_id_pipe.md
RISCV_ID_PIPE -- requirements
Module: riscv_id_pipe

Interface
REQ-001 Parameter XLEN, default 32: datapath width.
REQ-002 Parameter NREG, default 32: architectural register count; 32 is RV32I, 16 is RV32E.
REQ-003 Parameter WB_BYPASS, default 1: enables same-cycle WB-to-ID read bypass.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset.
REQ-005 Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  synchronous active-low reset.
- i_id_valid  in  1  instruction valid.
- i_id_instr  in  XLEN  instruction.
- i_id_pc  in  XLEN  instruction PC.
- i_id_wb_reg_write  in  1  WB write enable.
- i_id_rd_addr  in  5  WB destination.
- i_id_rd_data  in  XLEN  WB data.
- i_ex_flush  in  1  taken branch/jump kill.
- o_id_stall  out  1  hold IF/ID.
- o_ex_valid  out  1  ID/EX slot valid.
- o_ex_pc  out  XLEN  PC.
- o_ex_rs1_data, o_ex_rs2_data  out  XLEN  operands.
- o_ex_rs1_addr, o_ex_rs2_addr, o_ex_rd_addr  out  5  register addresses.
- o_ex_imm  out  XLEN  decoded immediate.
- o_ex_funct3  out  3  funct3.
- o_ex_ctrl  out  CTRL_W  packed control bundle.
- o_ex_illegal  out  1  register address not legal for NREG.
- o_id_stall_cnt  out  32  stall-cycle counter.

Function
REQ-006 The block SHALL decode i_id_instr combinationally using the existing control unit, immediate decoder and register file, and SHALL register all decode results into the ID/EX outputs on the next rising i_clk edge (1-cycle latency).
REQ-007 o_ex_ctrl SHALL pack reg_write, result_src[1:0], mem_write, jump[1:0], branch, alu_control[3:0], byte_sel[3:0], alu_b_src and rd_src (CTRL_W=17), in the field order fixed in the shared package.
REQ-008 Operand usage SHALL be derived from the opcode:
- rs1 is unused for LUI, AUIPC and JAL.
- rs2 is used only for R, S and B types.
REQ-009 A load-use hazard SHALL be detected when all of the following hold:
- i_id_valid=1 and o_ex_valid=1;
- o_ex_ctrl result_src=2'b01;
- o_ex_rd_addr!=0;
- o_ex_rd_addr equals a used rs address.
REQ-010 On a load-use hazard with i_ex_flush=0:
- o_id_stall SHALL be 1 in the same cycle (combinational).
- The next edge SHALL load a bubble: valid=0; reg_write, mem_write, branch and jump=0.
- The stall SHALL last exactly one cycle per hazard.
REQ-011 When i_ex_flush=1:
- The next edge SHALL load a bubble regardless of hazard.
- o_id_stall SHALL be 0 (flush overrides stall).
REQ-012 When i_id_valid=0, the next edge SHALL load a bubble, and o_id_stall SHALL be 0.
REQ-013 Reads of x0 SHALL return 0; writes to x0 SHALL be ignored.
REQ-014 With WB_BYPASS=1, when i_id_wb_reg_write=1, i_id_rd_addr!=0 and i_id_rd_addr equals rs1 (or rs2), that operand SHALL take i_id_rd_data in the same cycle; with WB_BYPASS=0, the register file value SHALL be used.
REQ-015 With NREG=16, a used rs address or rd with bit 4 set SHALL set o_ex_illegal=1 alongside o_ex_valid=1 and SHALL force reg_write=0; with NREG=32, o_ex_illegal SHALL always be 0.
REQ-016 o_id_stall_cnt SHALL increment by 1 on each edge where o_id_stall=1 and SHALL saturate at 32'hFFFF_FFFF.
REQ-017 Bubble slots SHALL still update the PC/address/imm fields; only valid and the side-effect controls are zeroed.

Reset
REQ-018 While i_rstn=0 at an edge, every o_ex_* output and o_id_stall_cnt SHALL become 0.
REQ-019 Register file contents SHALL NOT be reset.
REQ-020 A reset asserted during a stall cycle SHALL clear the ID/EX register, so o_id_stall is 0 in the following cycle.

Structure
REQ-021 XLEN default, CTRL_W, ctrl field offsets, opcode constants and the result_src load encoding SHALL live in the shared riscv_configs package.
REQ-022 Hazard detection and operand-usage decode SHALL be one sub-module, riscv_id_hazard (purely combinational).

Verification
REQ-023 Load-use stall:
- Stimulus: LW x5,0(x1), then ADD x6,x5,x2.
- Response: o_id_stall=1 for one cycle; one bubble (o_ex_valid=0); ADD issues next; o_id_stall_cnt=1.
REQ-024 No false stall:
- Stimulus: LW x5 followed by LUI x5,0x12345.
- Response: no stall; o_ex_imm=0x12345000.
REQ-025 Flush overrides stall:
- Stimulus: load-use hazard with i_ex_flush=1 in the same cycle.
- Response: o_id_stall=0; the next o_ex_valid=0.
REQ-026 WB bypass:
- Stimulus: write x7=0xDEADBEEF via WB in the same cycle ADD x8,x7,x0 decodes.
- Response: o_ex_rs1_data=0xDEADBEEF when WB_BYPASS=1; the stale register value when WB_BYPASS=0.
REQ-027 x0 and RV32E checks:
- Stimulus: a WB write of x0=0xFFFFFFFF, then a read of x0.
- Response: 0.
- Stimulus: with NREG=16, ADD x17,x1,x2.
- Response: o_ex_illegal=1, reg_write=0.
REQ-028 Reset and saturation:
- Stimulus: reset during a stall.
- Response: all outputs 0 next cycle.
- Stimulus: preload the counter to 0xFFFFFFFF, then stall.
- Response: the counter stays 0xFFFFFFFF.
